// File: rtl/bsg_bladerunner_rom_server_if.sv
// Request/response bundle between the host endpoint and the bladerunner ROM server.
// The master side issues requests and consumes responses; the slave side is the server.
interface bsg_bladerunner_rom_server_if #(
   parameter int unsigned width_p      = 32,
   parameter int unsigned addr_width_p = 5,
   parameter int unsigned tag_width_p  = 4
);
   logic                    req_v;
   logic [addr_width_p-1:0] req_addr;
   logic                    req_dump;
   logic [tag_width_p-1:0]  req_tag;
   logic                    req_ready;

   logic                    resp_v;
   logic [width_p-1:0]      resp_data;
   logic [tag_width_p-1:0]  resp_tag;
   logic                    resp_err;
   logic                    resp_last;
   logic                    resp_yumi;

   modport master (
      output req_v, req_addr, req_dump, req_tag,
      input  req_ready,
      input  resp_v, resp_data, resp_tag, resp_err, resp_last,
      output resp_yumi
   );

   modport slave (
      input  req_v, req_addr, req_dump, req_tag,
      output req_ready,
      output resp_v, resp_data, resp_tag, resp_err, resp_last,
      input  resp_yumi
   );
endinterface

// File: rtl/bsg_bladerunner_rom_server.sv
// Registered request/response front end for the combinational bladerunner config ROM.
// Serves single-word reads and full-ROM dump streams; range-checks and counts bad reads.
module bsg_bladerunner_rom_server #(
   parameter int unsigned width_p      = 32,
   parameter int unsigned addr_width_p = 5,
   parameter int unsigned els_p        = 20,
   parameter int unsigned tag_width_p  = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   bsg_bladerunner_rom_server_if.slave bus,
   output logic [addr_width_p-1:0] rom_addr_o,
   input  logic [width_p-1:0]      rom_data_i,
   output logic [7:0]              err_count_o
);

   localparam int unsigned AW  = addr_width_p;
   localparam int unsigned CW  = 8;
   localparam int unsigned AWX = addr_width_p + 1;

   typedef enum logic [1:0] {IDLE, SINGLE, DUMP} state_e;

   state_e                 state_q, state_d;
   logic                   resp_v_q, resp_v_d;
   logic [width_p-1:0]     resp_data_q, resp_data_d;
   logic [tag_width_p-1:0] resp_tag_q, resp_tag_d;
   logic                   resp_err_q, resp_err_d;
   logic                   resp_last_q, resp_last_d;
   logic [AW-1:0]          cnt_q, cnt_d;
   logic [CW-1:0]          err_cnt_q, err_cnt_d;

   logic          req_ready;
   logic          accept;
   logic          addr_err;
   logic          cnt_last;
   logic [AW-1:0] cnt_inc;

   // Compare one bit wider so els_p == 2^addr_width_p still fits.
   assign addr_err = {1'b0, bus.req_addr} >= AWX'(els_p);
   assign cnt_last = cnt_q == AW'(els_p - 1);
   assign cnt_inc  = cnt_q + AW'(1);

   // yumi -> ready is deliberately combinational to allow 1 read/cycle.
   assign req_ready = ~reset_i & ((state_q == IDLE) | ((state_q == SINGLE) & bus.resp_yumi));
   assign accept    = bus.req_v & req_ready;

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = bus.req_dump ? DUMP : SINGLE;
         end
         SINGLE: begin
            if (accept)              state_d = bus.req_dump ? DUMP : SINGLE;
            else if (bus.resp_yumi)  state_d = IDLE;
         end
         DUMP: begin
            if (bus.resp_yumi && cnt_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values; everything holds unless a handshake moves it
   always_comb begin
      resp_v_d    = resp_v_q;
      resp_data_d = resp_data_q;
      resp_tag_d  = resp_tag_q;
      resp_err_d  = resp_err_q;
      resp_last_d = resp_last_q;
      cnt_d       = cnt_q;
      err_cnt_d   = err_cnt_q;
      rom_addr_o  = bus.req_dump ? '0 : bus.req_addr;

      if (state_q == DUMP)
         rom_addr_o = (bus.resp_yumi && !cnt_last) ? cnt_inc : cnt_q;

      if (accept) begin
         resp_v_d   = 1'b1;
         resp_tag_d = bus.req_tag;
         if (bus.req_dump) begin
            cnt_d       = '0;
            resp_data_d = rom_data_i;
            resp_err_d  = 1'b0;
            resp_last_d = (els_p == 1);
         end else begin
            resp_data_d = addr_err ? '0 : rom_data_i;
            resp_err_d  = addr_err;
            resp_last_d = 1'b1;
            if (addr_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CW'(1);
         end
      end else if ((state_q == DUMP) && bus.resp_yumi) begin
         if (cnt_last) begin
            resp_v_d = 1'b0;
         end else begin
            cnt_d       = cnt_inc;
            resp_data_d = rom_data_i;
            resp_last_d = (cnt_inc == AW'(els_p - 1));
         end
      end else if ((state_q == SINGLE) && bus.resp_yumi) begin
         resp_v_d = 1'b0;
      end
   end

   // Response and counter registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         resp_v_q    <= 1'b0;
         resp_data_q <= '0;
         resp_tag_q  <= '0;
         resp_err_q  <= 1'b0;
         resp_last_q <= 1'b0;
         cnt_q       <= '0;
         err_cnt_q   <= '0;
      end else begin
         resp_v_q    <= resp_v_d;
         resp_data_q <= resp_data_d;
         resp_tag_q  <= resp_tag_d;
         resp_err_q  <= resp_err_d;
         resp_last_q <= resp_last_d;
         cnt_q       <= cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.resp_v    = resp_v_q;
   assign bus.resp_data = resp_data_q;
   assign bus.resp_tag  = resp_tag_q;
   assign bus.resp_err  = resp_err_q;
   assign bus.resp_last = resp_last_q;
   assign err_count_o   = err_cnt_q;

endmodule

// File: tb/tb_bsg_bladerunner_rom_server.sv
// Directed bench for bsg_bladerunner_rom_server with a behavioural ROM table.
module tb_bsg_bladerunner_rom_server;

   localparam int unsigned W   = 32;
   localparam int unsigned AW  = 5;
   localparam int unsigned ELS = 20;
   localparam int unsigned TW  = 4;

   logic          clk = 1'b0;
   logic          reset_i;
   logic [AW-1:0] rom_addr;
   logic [W-1:0]  rom_data;
   logic [7:0]    err_count;
   logic [W-1:0]  rom_mem [0:31];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bsg_bladerunner_rom_server_if #(.width_p(W), .addr_width_p(AW), .tag_width_p(TW)) bus ();

   bsg_bladerunner_rom_server #(
      .width_p(W), .addr_width_p(AW), .els_p(ELS), .tag_width_p(TW)
   ) dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .bus        (bus),
      .rom_addr_o (rom_addr),
      .rom_data_i (rom_data),
      .err_count_o(err_count)
   );

   assign rom_data = rom_mem[rom_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_resp(input string tag, input logic [31:0] data, input logic [3:0] rtag,
                           input logic err, input logic last);
      chk({tag, "_v"},    32'(bus.resp_v), 32'd1);
      chk({tag, "_data"}, bus.resp_data, data);
      chk({tag, "_tag"},  32'(bus.resp_tag), 32'(rtag));
      chk({tag, "_err"},  32'(bus.resp_err), 32'(err));
      chk({tag, "_last"}, 32'(bus.resp_last), 32'(last));
   endtask

   initial begin
      int k;
      logic y;

      // ROM image: known words at the planned addresses, filler elsewhere (nonzero past els)
      for (int i = 0; i < 32; i++) rom_mem[i] = 32'hA5000000 | (32'(i) * 32'h00010203);
      rom_mem[0]  = 32'h00030602;
      rom_mem[9]  = 32'h07EC9D3E;
      rom_mem[10] = 32'h02C7C53C;
      rom_mem[11] = 32'h05B05674;
      rom_mem[19] = 32'h000000C8;

      reset_i       = 1'b1;
      bus.req_v     = 1'b0;
      bus.req_addr  = '0;
      bus.req_dump  = 1'b0;
      bus.req_tag   = '0;
      bus.resp_yumi = 1'b0;

      // Reset state
      tick(); tick(); tick();
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_v",     32'(bus.resp_v), 32'd0);
      chk("rst_data",  bus.resp_data, 32'd0);
      chk("rst_tag",   32'(bus.resp_tag), 32'd0);
      chk("rst_err",   32'(bus.resp_err), 32'd0);
      chk("rst_last",  32'(bus.resp_last), 32'd0);
      chk("rst_errcnt", 32'(err_count), 32'd0);
      reset_i = 1'b0;
      #1;
      chk("idle_ready", 32'(bus.req_ready), 32'd1);

      // Single read addr 0 tag 3, then hold without yumi
      bus.req_v = 1'b1; bus.req_addr = 5'd0; bus.req_tag = 4'd3;
      #1;
      chk("s0_romaddr", 32'(rom_addr), 32'd0);
      tick();
      bus.req_v = 1'b0;
      chk_resp("s0", 32'h00030602, 4'd3, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_resp("s0_hold", 32'h00030602, 4'd3, 1'b0, 1'b1);
         chk("s0_hold_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_yumi = 1'b1;
      #1;
      chk("s0_yumi_ready", 32'(bus.req_ready), 32'd1);
      tick();
      bus.resp_yumi = 1'b0;
      chk("s0_drop_v", 32'(bus.resp_v), 32'd0);

      // Back-to-back single reads 9, 10, 11 with yumi held high
      bus.req_v = 1'b1; bus.req_addr = 5'd9; bus.req_tag = 4'd9;
      #1;
      chk("b2b_ready0", 32'(bus.req_ready), 32'd1);
      tick();
      chk_resp("b2b9", 32'h07EC9D3E, 4'd9, 1'b0, 1'b1);
      bus.resp_yumi = 1'b1;
      for (int j = 10; j <= 11; j++) begin
         bus.req_addr = 5'(j); bus.req_tag = 4'(j);
         #1;
         chk("b2b_ready", 32'(bus.req_ready), 32'd1);
         tick();
         chk_resp("b2b", (j == 10) ? 32'h02C7C53C : 32'h05B05674, 4'(j), 1'b0, 1'b1);
      end
      bus.req_v = 1'b0;
      tick();
      bus.resp_yumi = 1'b0;
      chk("b2b_end_v", 32'(bus.resp_v), 32'd0);

      // Out-of-range single reads and saturation of the error counter
      bus.req_v = 1'b1; bus.req_addr = 5'd25; bus.req_tag = 4'd5;
      tick();
      chk_resp("oor", 32'd0, 4'd5, 1'b1, 1'b1);
      chk("oor_cnt1", 32'(err_count), 32'd1);
      bus.resp_yumi = 1'b1;
      for (int i = 1; i <= 299; i++) begin
         tick();
         if (i == 199) chk("oor_cnt200", 32'(err_count), 32'd200);
         if (i == 254) chk("oor_cnt255", 32'(err_count), 32'd255);
      end
      bus.req_v = 1'b0;
      tick();
      bus.resp_yumi = 1'b0;
      chk("oor_sat", 32'(err_count), 32'd255);
      chk("oor_end_v", 32'(bus.resp_v), 32'd0);

      // Dump with continuous yumi; address input must be ignored
      bus.req_v = 1'b1; bus.req_dump = 1'b1; bus.req_addr = 5'd5; bus.req_tag = 4'd7;
      #1;
      chk("dump_romaddr0", 32'(rom_addr), 32'd0);
      tick();
      bus.req_v = 1'b0; bus.req_dump = 1'b0;
      bus.resp_yumi = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk_resp("dump", rom_mem[i], 4'd7, 1'b0, (i == 19));
         chk("dump_ready", 32'(bus.req_ready), 32'd0);
         tick();
      end
      bus.resp_yumi = 1'b0;
      chk("dump_end_v", 32'(bus.resp_v), 32'd0);
      chk("dump_errcnt", 32'(err_count), 32'd255);

      // Dump with random yumi throttling
      bus.req_v = 1'b1; bus.req_dump = 1'b1; bus.req_tag = 4'd2;
      tick();
      bus.req_v = 1'b0; bus.req_dump = 1'b0;
      k = 0;
      for (int c = 0; c < 400 && k < 20; c++) begin
         chk_resp("thr", rom_mem[k], 4'd2, 1'b0, (k == 19));
         y = 1'($urandom_range(0, 1));
         bus.resp_yumi = y;
         tick();
         if (y) k++;
      end
      bus.resp_yumi = 1'b0;
      chk("thr_count", 32'(k), 32'd20);
      chk("thr_end_v", 32'(bus.resp_v), 32'd0);

      // Reset in the middle of a dump
      bus.req_v = 1'b1; bus.req_dump = 1'b1; bus.req_tag = 4'd1;
      tick();
      bus.req_v = 1'b0; bus.req_dump = 1'b0;
      bus.resp_yumi = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk_resp("mid", rom_mem[8], 4'd1, 1'b0, 1'b0);
      reset_i = 1'b1;
      bus.resp_yumi = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
      tick();
      reset_i = 1'b0;
      chk("mid_rst_v", 32'(bus.resp_v), 32'd0);
      chk("mid_rst_errcnt", 32'(err_count), 32'd0);
      bus.req_v = 1'b1; bus.req_addr = 5'd19; bus.req_tag = 4'd4;
      #1;
      chk("mid_rst_ready1", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_v = 1'b0;
      chk_resp("post_rst", 32'h000000C8, 4'd4, 1'b0, 1'b1);
      bus.resp_yumi = 1'b1;
      tick();
      bus.resp_yumi = 1'b0;
      chk("post_rst_end_v", 32'(bus.resp_v), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
